// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one non-pipelined data-memory port between the instruction-fetch requester (IF)
//   and the load/store requester (LS). One access is in flight at a time. LS normally wins
//   arbitration, but after STARVE_MAX consecutive LS grants with IF waiting, IF is granted.
//   Misaligned or out-of-range LS accesses are answered with an error and never reach memory.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req_valid/ready/addr         IF read request handshake
//   if_rsp_valid/data               IF read response (one-cycle pulse)
//   ls_req_valid/ready/we/addr/wdata LS request handshake
//   ls_rsp_valid/data/err           LS completion (one-cycle pulse)
//   mem_rd_en/wr_en/addr/wr_data    memory request, strobes one cycle wide
//   mem_rd_data                     memory read data, valid the cycle after mem_rd_en
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_BYTES  = 2048,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_we,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,

    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int unsigned CNT_W      = $clog2(STARVE_MAX + 1);

    localparam logic [ADDR_W-1:0] OFF_MASK     = ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]   WORD_BYTES_X = (ADDR_W + 1)'(WORD_BYTES);
    localparam logic [ADDR_W:0]   MEM_BYTES_X  = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [CNT_W-1:0]  STARVE_LIM   = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                owner_ls_q, owner_ls_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic                ls_rsp_valid_q, ls_rsp_valid_d;
    logic                ls_rsp_err_q, ls_rsp_err_d;

    logic arb_phase, if_force, ls_wins, if_wins;
    logic if_acc, ls_acc, acc, ls_err;

    // Arbitration. With no requester valid both readies stay high; once a winner exists
    // only the winner sees ready.
    always_comb begin
        arb_phase    = (state_q != StIssue);
        if_force     = (starve_q == STARVE_LIM) && if_req_valid;
        ls_wins      = ls_req_valid && !if_force;
        if_wins      = if_req_valid && !ls_wins;
        if_req_ready = arb_phase && !ls_wins;
        ls_req_ready = arb_phase && !if_wins;
        if_acc       = if_req_valid && if_req_ready;
        ls_acc       = ls_req_valid && ls_req_ready;
        acc          = if_acc || ls_acc;
        // Widened by one bit so addr + WORD_BYTES cannot wrap.
        ls_err       = ((ls_req_addr & OFF_MASK) != '0) ||
                       (({1'b0, ls_req_addr} + WORD_BYTES_X) > MEM_BYTES_X);
    end

    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        owner_ls_d     = owner_ls_q;
        we_d           = we_q;
        err_d          = err_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        mem_rd_en_d    = 1'b0;
        mem_wr_en_d    = 1'b0;
        if_rsp_valid_d = 1'b0;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (acc) state_d = StIssue;
            end
            StIssue: begin
                state_d        = StResp;
                if_rsp_valid_d = !owner_ls_q;
                ls_rsp_valid_d = owner_ls_q;
                ls_rsp_err_d   = owner_ls_q && err_q;
            end
            StResp: begin
                state_d = acc ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // acc can only be true outside StIssue because ready is gated there.
        if (acc) begin
            owner_ls_d    = ls_acc;
            we_d          = ls_acc && ls_req_we;
            err_d         = ls_acc && ls_err;
            mem_addr_d    = ls_acc ? ls_req_addr : if_req_addr;
            mem_wr_data_d = ls_acc ? ls_req_wdata : '0;
            mem_rd_en_d   = !we_d && !err_d;
            mem_wr_en_d   = we_d && !err_d;
        end

        if (!if_req_valid || if_acc) begin
            starve_d = '0;
        end else if (ls_acc && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            starve_q       <= '0;
            owner_ls_q     <= 1'b0;
            we_q           <= 1'b0;
            err_q          <= 1'b0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_wr_en_q    <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            owner_ls_q     <= owner_ls_d;
            we_q           <= we_d;
            err_q          <= err_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_wr_en_q    <= mem_wr_en_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_err_q   <= ls_rsp_err_d;
        end
    end

    // Read data arrives from memory during the response cycle, so it is passed through
    // rather than registered. we_q/err_q still describe the responding access here.
    always_comb begin
        mem_rd_en    = mem_rd_en_q;
        mem_wr_en    = mem_wr_en_q;
        mem_addr     = mem_addr_q;
        mem_wr_data  = mem_wr_data_q;
        if_rsp_valid = if_rsp_valid_q;
        ls_rsp_valid = ls_rsp_valid_q;
        ls_rsp_err   = ls_rsp_err_q;
        if_rsp_data  = if_rsp_valid_q ? mem_rd_data : '0;
        ls_rsp_data  = (ls_rsp_valid_q && !we_q && !err_q) ? mem_rd_data : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_we;
    logic [31:0] ls_req_addr;
    logic [63:0] ls_req_wdata;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [63:0] mem_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(64), .MEM_BYTES(2048), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    function automatic logic [63:0] init_word(input int i);
        if (i == 2) return 64'h1122_3344_5566_7788;
        return {32'(i), 32'hC0DE_0000};
    endfunction

    // Memory model: 256 words, read data one cycle after the read strobe.
    logic [63:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_rd_data <= '0;
        end else begin
            if (mem_wr_en) mem[mem_addr[10:3]] <= mem_wr_data;
            if (mem_rd_en) mem_rd_data <= mem[mem_addr[10:3]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic if_access(input logic [31:0] addr, input logic [63:0] exp_data);
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        #1;
        check("if_ready_idle", if_req_ready, 1);
        step();
        if_req_valid = 1'b0;
        if_req_addr  = 32'hFFFF_FFF8;
        #1;
        check("if_issue_rd_en", mem_rd_en, 1);
        check("if_issue_addr", mem_addr, addr);
        check("if_issue_ready", if_req_ready | ls_req_ready, 0);
        check("if_issue_rsp", if_rsp_valid, 0);
        step();
        #1;
        check("if_rsp_valid", if_rsp_valid, 1);
        check("if_rsp_data", if_rsp_data, exp_data);
        check("if_rsp_rd_en", mem_rd_en, 0);
        check("if_rsp_ls_valid", ls_rsp_valid, 0);
        step();
        #1;
        check("if_rsp_pulse", if_rsp_valid, 0);
    endtask

    task automatic ls_access(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                             input logic exp_err, input logic [63:0] exp_data);
        ls_req_valid = 1'b1;
        ls_req_we    = we;
        ls_req_addr  = addr;
        ls_req_wdata = wd;
        #1;
        check("ls_ready_idle", ls_req_ready, 1);
        step();
        ls_req_valid = 1'b0;
        ls_req_we    = ~we;
        ls_req_addr  = 32'h0000_0100;
        ls_req_wdata = '1;
        #1;
        check("ls_issue_rd_en", mem_rd_en, !we && !exp_err);
        check("ls_issue_wr_en", mem_wr_en, we && !exp_err);
        if (!exp_err) check("ls_issue_addr", mem_addr, addr);
        if (we && !exp_err) check("ls_issue_wdata", mem_wr_data, wd);
        check("ls_issue_rsp", ls_rsp_valid, 0);
        step();
        #1;
        check("ls_rsp_valid", ls_rsp_valid, 1);
        check("ls_rsp_err", ls_rsp_err, exp_err);
        check("ls_rsp_data", ls_rsp_data, exp_data);
        check("ls_rsp_strobes", mem_rd_en | mem_wr_en, 0);
        check("ls_rsp_if_valid", if_rsp_valid, 0);
        step();
        #1;
        check("ls_rsp_pulse", ls_rsp_valid, 0);
    endtask

    // Both requesters held valid; with STARVE_MAX=4 every fifth grant goes to IF.
    task automatic run_grants(input int n);
        int k;
        k            = 0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b0;
        ls_req_addr  = 32'h40;
        for (int c = 0; c < 4 * n && k < n; c++) begin
            #1;
            if (if_req_ready || ls_req_ready) begin
                check($sformatf("grant_%0d_is_if", k), if_req_ready, (k % 5) == 4);
                check($sformatf("grant_%0d_excl", k), if_req_ready & ls_req_ready, 0);
                k++;
            end
            step();
        end
        if (k < n) check("grant_timeout", k, n);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [31:0] addrs [3];
        int idx;
        reset        = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        ls_req_valid = 1'b0;
        ls_req_we    = 1'b0;
        ls_req_addr  = '0;
        ls_req_wdata = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_if_ready", if_req_ready, 1);
        check("rst_ls_ready", ls_req_ready, 1);
        check("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
        check("rst_rsp_valid", {if_rsp_valid, ls_rsp_valid, ls_rsp_err}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_data", if_rsp_data | ls_rsp_data, 0);
        step();

        // IF-only read
        if_access(32'h10, 64'h1122_3344_5566_7788);

        // LS store, then read it back through IF
        ls_access(1'b1, 32'h40, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0);
        if_access(32'h40, 64'h0000_0000_DEAD_BEEF);

        // Starvation override
        run_grants(10);

        // Illegal and boundary LS accesses
        ls_access(1'b0, 32'h43, '0, 1'b1, 64'h0);
        ls_access(1'b0, 32'd2044, '0, 1'b1, 64'h0);
        ls_access(1'b0, 32'd2048, '0, 1'b1, 64'h0);
        ls_access(1'b1, 32'h41, 64'h55, 1'b1, 64'h0);
        ls_access(1'b0, 32'd2040, '0, 1'b0, init_word(255));

        // Back-to-back LS loads: accepts at N, N+2, N+4
        addrs[0]     = 32'h08;
        addrs[1]     = 32'h10;
        addrs[2]     = 32'h18;
        idx          = 0;
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b0;
        ls_req_addr  = addrs[0];
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("b2b_ready_%0d", c), ls_req_ready, (c % 2) == 0);
            check($sformatf("b2b_rsp_%0d", c), ls_rsp_valid, c == 2 || c == 4);
            if (c == 2) check("b2b_data_0", ls_rsp_data, init_word(1));
            if (c == 4) check("b2b_data_1", ls_rsp_data, init_word(2));
            step();
            if ((c % 2) == 0 && idx < 2) begin
                idx++;
                ls_req_addr = addrs[idx];
            end
        end
        ls_req_valid = 1'b0;
        step();
        #1;
        check("b2b_rsp_last", ls_rsp_valid, 1);
        check("b2b_data_2", ls_rsp_data, init_word(3));
        step();

        // Reset during ISSUE, with the starvation counter part-way up
        if_req_valid = 1'b1;
        if_req_addr  = 32'h10;
        ls_req_valid = 1'b1;
        ls_req_addr  = 32'h40;
        step();
        step();
        step();
        reset        = 1'b1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        #1;
        check("rst6_pre_rd_en", mem_rd_en, 1);
        step();
        reset = 1'b0;
        #1;
        check("rst6_strobes", {mem_rd_en, mem_wr_en}, 0);
        check("rst6_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
        check("rst6_ready", {if_req_ready, ls_req_ready}, 2'b11);
        step();
        #1;
        check("rst6_no_late_rsp", {if_rsp_valid, ls_rsp_valid, mem_rd_en}, 0);
        step();
        // A cleared counter gives four LS grants before IF.
        run_grants(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
